// File: rtl/cla_seq_adder_if.sv
// Request/response bundle for cla_seq_adder. The master drives operands and
// accepts results; the slave is the adder.
interface cla_seq_adder_if #(
  parameter int W = 16
);
  logic         start_valid;
  logic         start_ready;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         cin;
  logic         sub;
  logic         res_valid;
  logic         res_ready;
  logic [W-1:0] sum;
  logic         cout;
  logic         ovf;
  logic         busy;

  modport master (
    output start_valid, a, b, cin, sub, res_ready,
    input  start_ready, res_valid, sum, cout, ovf, busy
  );

  modport slave (
    input  start_valid, a, b, cin, sub, res_ready,
    output start_ready, res_valid, sum, cout, ovf, busy
  );
endinterface

// File: rtl/cla_seq_adder.sv
// Wide add/sub sequenced through one 4-bit CLA, LSB nibble first: result valid NIBBLES
// cycles after acceptance; the result is held in DONE until res_ready, no new request meanwhile.
module cla_seq_adder #(
  parameter int NIBBLES = 4
) (
  input  logic          clk,
  input  logic          rst,
  cla_seq_adder_if.slave io
);
  localparam int W  = 4 * NIBBLES;
  localparam int IW = $clog2(NIBBLES);
  localparam logic [IW-1:0] LAST_IDX = IW'(NIBBLES - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t        state_q, state_d;
  logic [IW-1:0] idx_q, idx_d;
  logic          carry_q, carry_d;
  logic [W-1:0]  a_q, a_d;
  logic [W-1:0]  b_q, b_d;
  logic [W-1:0]  sum_q, sum_d;
  logic          cout_q, cout_d;
  logic          ovf_q, ovf_d;

  logic [IW+1:0] bit_base;
  logic [3:0]    nib_a;
  logic [3:0]    nib_b;
  logic [3:0]    nib_sum;
  logic          nib_cout;

  assign bit_base = {idx_q, 2'b00};
  assign nib_a    = a_q[bit_base +: 4];
  assign nib_b    = b_q[bit_base +: 4];

  CLA u_cla (
    .a    (nib_a),
    .b    (nib_b),
    .cin  (carry_q),
    .sum  (nib_sum),
    .cout (nib_cout)
  );

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    carry_d = carry_q;
    a_d     = a_q;
    b_d     = b_q;
    sum_d   = sum_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;

    case (state_q)
      IDLE: begin
        if (io.start_valid) begin
          // Subtraction is folded into the operands: A + ~B + 1.
          a_d     = io.a;
          b_d     = io.sub ? ~io.b : io.b;
          carry_d = io.sub ? 1'b1 : io.cin;
          idx_d   = '0;
          sum_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        sum_d[bit_base +: 4] = nib_sum;
        carry_d              = nib_cout;
        idx_d                = idx_q + 1'b1;
        if (idx_q == LAST_IDX) begin
          // nib_sum[3] is the new MSB of the full-width result on the last nibble.
          cout_d  = nib_cout;
          ovf_d   = (a_q[W-1] == b_q[W-1]) && (nib_sum[3] != a_q[W-1]);
          idx_d   = idx_q;
          state_d = DONE;
        end
      end
      DONE: begin
        if (io.res_ready) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      idx_q   <= '0;
      carry_q <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      carry_q <= carry_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
    end
  end

  assign io.start_ready = (state_q == IDLE);
  assign io.res_valid   = (state_q == DONE);
  assign io.busy        = (state_q != IDLE);
  assign io.sum         = sum_q;
  assign io.cout        = cout_q;
  assign io.ovf         = ovf_q;
endmodule

// 4-bit carry-lookahead adder slice; purely combinational.
module CLA (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       cin,
  output logic [3:0] sum,
  output logic       cout
);
  logic [3:0] p;
  logic [3:0] g;
  logic [3:0] c;

  assign p = a ^ b;
  assign g = a & b;

  assign c[0] = cin;
  assign c[1] = g[0] | (p[0] & cin);
  assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cin);
  assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & cin);
  assign cout = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
              | (p[3] & p[2] & p[1] & p[0] & cin);

  assign sum = p ^ c;
endmodule
